// File: rtl/mult_seq_ctrl_if.sv
// Button, operand and result bundle of the multiply-and-display sequencer.
// The controller takes the slave side; whoever drives buttons and operands takes the master side.
interface mult_seq_ctrl_if #(
    parameter int W  = 8,
    parameter int ND = 5
);
    logic [W-1:0]    X;
    logic [W-1:0]    Y;
    logic            startMult;
    logic            scrLeft;
    logic            scrRight;
    logic            busy;
    logic            done;
    logic [2*W-1:0]  product;
    logic [4*ND-1:0] bcd;
    logic [2:0]      win_pos;
    logic [15:0]     win_digits;
    logic            more_left;

    modport master (
        output X, Y, startMult, scrLeft, scrRight,
        input  busy, done, product, bcd, win_pos, win_digits, more_left
    );

    modport slave (
        input  X, Y, startMult, scrLeft, scrRight,
        output busy, done, product, bcd, win_pos, win_digits, more_left
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Button sync/edge-detect, shift-add multiply, double-dabble BCD and 4-digit display window.
// Define BTN_DEBOUNCE_EN to insert a DB_CYCLES debounce counter behind each synchroniser.
module mult_seq_ctrl #(
    parameter int W         = 8,
    parameter int ND        = 5,
    parameter int DB_CYCLES = 16
) (
    input  logic           clkin,
    input  logic           rst,
    mult_seq_ctrl_if.slave bus
);
    localparam int         CW      = $clog2(2*W + 1);
    localparam logic [2:0] POS_MAX = 3'(ND - 4);
    localparam int         BS = 0;
    localparam int         BL = 1;
    localparam int         BR = 2;

    if (ND < 4 || DB_CYCLES < 1) begin : g_bad_params
        $error("mult_seq_ctrl: ND must be >= 4 and DB_CYCLES >= 1");
    end

    typedef enum logic [1:0] {IDLE, MULT, BCD, DONE} state_t;
    state_t state;

    logic [2:0] raw, sync1, sync2, lvl, prev, pulse;
    assign raw = {bus.scrRight, bus.scrLeft, bus.startMult};

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

`ifdef BTN_DEBOUNCE_EN
    localparam int DW = $clog2(DB_CYCLES + 1);
    logic [DW-1:0] db_cnt [3];

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            lvl <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != lvl[i]) begin
                    if (db_cnt[i] == DW'(DB_CYCLES - 1)) begin
                        lvl[i]    <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end
`else
    assign lvl = sync2;
`endif

    assign pulse = lvl & ~prev;

    logic [2*W-1:0]  a, acc, bin, acc_next, product;
    logic [W-1:0]    b;
    logic [4*ND-1:0] digits, dig_adj, dig_next, bcd;
    logic [CW-1:0]   cnt;
    logic [2:0]      win_pos;
    logic            busy, done;

    always_comb begin
        acc_next = acc + (b[0] ? a : '0);
        dig_adj  = '0;
        for (int d = 0; d < ND; d++) begin
            dig_adj[4*d +: 4] = (digits[4*d +: 4] >= 4'd5) ? digits[4*d +: 4] + 4'd3
                                                           : digits[4*d +: 4];
        end
        dig_next = {dig_adj[4*ND-2:0], bin[2*W-1]};
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            prev    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            bcd     <= '0;
            win_pos <= '0;
            a       <= '0;
            b       <= '0;
            acc     <= '0;
            bin     <= '0;
            digits  <= '0;
            cnt     <= '0;
        end else begin
            prev <= lvl;
            done <= 1'b0;
            if (pulse[BL] && !pulse[BR] && win_pos < POS_MAX)
                win_pos <= win_pos + 3'd1;
            else if (pulse[BR] && !pulse[BL] && win_pos != 3'd0)
                win_pos <= win_pos - 3'd1;

            case (state)
                IDLE: if (pulse[BS]) begin
                    a     <= (2*W)'(bus.X);
                    b     <= bus.Y;
                    acc   <= '0;
                    cnt   <= CW'(W);
                    busy  <= 1'b1;
                    state <= MULT;
                end
                MULT: begin
                    acc <= acc_next;
                    a   <= a << 1;
                    b   <= b >> 1;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        product <= acc_next;
                        bin     <= acc_next;
                        digits  <= '0;
                        cnt     <= CW'(2*W);
                        state   <= BCD;
                    end
                end
                BCD: begin
                    digits <= dig_next;
                    bin    <= bin << 1;
                    cnt    <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        bcd   <= dig_next;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // window snaps home on every new result, overriding any scroll this cycle
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    win_pos <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [5:0]      sh_lo, sh_hi;
    logic [4*ND-1:0] win_shift;

    always_comb begin
        sh_lo     = {1'b0, win_pos, 2'b00};
        sh_hi     = sh_lo + 6'd16;
        win_shift = bcd >> sh_lo;
    end

    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.product    = product;
    assign bus.bcd        = bcd;
    assign bus.win_pos    = win_pos;
    assign bus.win_digits = win_shift[15:0];
    assign bus.more_left  = |(bcd >> sh_hi);
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl (default build): directed plan plus randomized buttons/operands
// checked every cycle against a decimal-arithmetic reference model.
`timescale 1ns/1ps
module tb_mult_seq_ctrl;
    localparam int W  = 8;
    localparam int ND = 5;

    logic clkin = 1'b0;
    logic rst   = 1'b1;
    bit   checking = 1'b0;

    mult_seq_ctrl_if #(.W(W), .ND(ND)) bus();
    mult_seq_ctrl #(.W(W), .ND(ND), .DB_CYCLES(16)) dut (
        .clkin(clkin),
        .rst  (rst),
        .bus  (bus.slave)
    );

    always #5 clkin = ~clkin;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    function automatic int unsigned pow10(input int e);
        int unsigned r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [31:0] to_bcd(input int unsigned v);
        logic [31:0] r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Reference model: timeline counted in clock edges since the start was accepted.
    bit          m_busy, m_done;
    int          m_t, m_pos;
    int unsigned m_p, m_prod, m_bval;
    bit [2:0]    q0, q1, q2, ps;

    always @(posedge clkin or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_t = 0; m_pos = 0;
            m_p = 0; m_prod = 0; m_bval = 0;
            q0 = 0; q1 = 0; q2 = 0;
        end else begin
            ps     = q1 & ~q2;
            m_done = 0;
            if (m_busy) begin
                m_t++;
                if (m_t == W)   m_prod = m_p;
                if (m_t == 3*W) m_bval = m_p;
            end
            if (ps[1] && !ps[2] && m_pos < ND - 4) m_pos++;
            else if (ps[2] && !ps[1] && m_pos > 0) m_pos--;
            if (m_busy && m_t == 3*W + 1) begin
                m_busy = 0; m_done = 1; m_pos = 0;
            end else if (!m_busy && ps[0]) begin
                m_busy = 1; m_t = 0; m_p = bus.X * bus.Y;
            end
            q2 = q1; q1 = q0;
            q0 = {bus.scrRight, bus.scrLeft, bus.startMult};
        end
    end

    always @(negedge clkin) begin
        if (checking && !rst) begin
            check("busy",       bus.busy,       m_busy);
            check("done",       bus.done,       m_done);
            check("product",    bus.product,    m_prod);
            check("bcd",        bus.bcd,        to_bcd(m_bval) & 32'hFFFFF);
            check("win_pos",    bus.win_pos,    m_pos);
            check("win_digits", bus.win_digits, to_bcd(m_bval / pow10(m_pos)) & 32'hFFFF);
            check("more_left",  bus.more_left,  (m_bval / pow10(m_pos + 4)) != 0);
        end
    end

    task automatic press(input int which, input int cycles);
        case (which)
            0: bus.startMult = 1'b1;
            1: bus.scrLeft   = 1'b1;
            default: bus.scrRight = 1'b1;
        endcase
        repeat (cycles) @(negedge clkin);
        bus.startMult = 1'b0;
        bus.scrLeft   = 1'b0;
        bus.scrRight  = 1'b0;
        repeat (3) @(negedge clkin);
    endtask

    task automatic wait_done();
        int c = 0;
        while (!bus.done && c < 100) begin
            @(negedge clkin);
            c++;
        end
        check("done_seen", bus.done, 1);
        repeat (2) @(negedge clkin);
    endtask

    task automatic do_mult(input logic [7:0] x, input logic [7:0] y);
        bus.X = x;
        bus.Y = y;
        bus.startMult = 1'b1;
        repeat (4) @(negedge clkin);
        bus.startMult = 1'b0;
        wait_done();
    endtask

    initial begin
        int n, ndone, gaps, k;
        bus.X = '0; bus.Y = '0;
        bus.startMult = 0; bus.scrLeft = 0; bus.scrRight = 0;
        repeat (3) @(negedge clkin);
        #1;
        check("rst_busy",    bus.busy,    0);
        check("rst_done",    bus.done,    0);
        check("rst_product", bus.product, 0);
        check("rst_bcd",     bus.bcd,     0);
        check("rst_win_pos", bus.win_pos, 0);
        rst = 1'b0;
        checking = 1'b1;
        @(negedge clkin);

        // long press: one run only
        bus.X = 8'd13; bus.Y = 8'd5; bus.startMult = 1'b1;
        ndone = 0;
        repeat (1000) begin
            @(negedge clkin);
            if (bus.done) ndone++;
        end
        bus.startMult = 1'b0;
        repeat (5) @(negedge clkin);
        check("long_press_done_count", ndone, 1);
        check("p13x5_product", bus.product,    16'h0041);
        check("p13x5_bcd",     bus.bcd,        20'h00065);
        check("p13x5_win",     bus.win_digits, 16'h0065);
        check("p13x5_more",    bus.more_left,  0);

        do_mult(8'd255, 8'd255);
        check("p255_product", bus.product,    16'hFE01);
        check("p255_bcd",     bus.bcd,        20'h65025);
        check("p255_win",     bus.win_digits, 16'h5025);
        check("p255_more",    bus.more_left,  1);
        press(1, 3);
        check("scrl1_pos",  bus.win_pos,    1);
        check("scrl1_win",  bus.win_digits, 16'h6502);
        check("scrl1_more", bus.more_left,  0);
        press(1, 3);
        check("scrl_sat_pos", bus.win_pos, 1);
        press(2, 3);
        check("scrr_pos", bus.win_pos, 0);

        // latency: start sampled -> busy, busy -> done
        bus.X = 8'd0; bus.Y = 8'd200; bus.startMult = 1'b1;
        n = 0;
        while (!bus.busy && n < 10) begin @(negedge clkin); n++; end
        check("start_latency", n, 3);
        bus.startMult = 1'b0;
        n = 0;
        while (!bus.done && n < 60) begin @(negedge clkin); n++; end
        check("done_latency", n, 25);
        check("p0_product", bus.product, 0);
        check("p0_bcd",     bus.bcd,     0);
        repeat (2) @(negedge clkin);
        do_mult(8'd1, 8'd1);
        check("p1_product", bus.product, 1);
        check("p1_bcd",     bus.bcd,     1);

        // second start while busy is ignored
        bus.X = 8'd9; bus.Y = 8'd11; bus.startMult = 1'b1;
        n = 0;
        while (!bus.busy && n < 10) begin @(negedge clkin); n++; end
        bus.startMult = 1'b0;
        gaps = 0; n = 0;
        while (!bus.done && n < 60) begin
            if (!bus.busy) gaps++;
            if (n == 6) begin bus.X = 8'd7; bus.startMult = 1'b1; end
            if (n == 10) bus.startMult = 1'b0;
            @(negedge clkin);
            n++;
        end
        check("busy_gaps",  gaps, 0);
        check("p99_product", bus.product, 16'h0063);
        check("p99_bcd",     bus.bcd,     20'h00099);
        repeat (5) @(negedge clkin);

        // reset during MULT
        press(1, 3);
        check("pre_rst_pos", bus.win_pos, 1);
        bus.X = 8'd200; bus.Y = 8'd3; bus.startMult = 1'b1;
        n = 0;
        while (!bus.busy && n < 10) begin @(negedge clkin); n++; end
        bus.startMult = 1'b0;
        @(negedge clkin);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy",    bus.busy,    0);
        check("midrst_product", bus.product, 0);
        check("midrst_bcd",     bus.bcd,     0);
        check("midrst_win_pos", bus.win_pos, 0);
        @(negedge clkin);
        #2 rst = 1'b0;
        @(negedge clkin);
        do_mult(8'd200, 8'd3);
        check("p600_product", bus.product, 16'h0258);
        check("p600_bcd",     bus.bcd,     20'h00600);

        // simultaneous scroll
        press(1, 3);
        bus.scrLeft = 1'b1; bus.scrRight = 1'b1;
        repeat (3) @(negedge clkin);
        bus.scrLeft = 1'b0; bus.scrRight = 1'b0;
        repeat (3) @(negedge clkin);
        check("both_scroll_pos", bus.win_pos, 1);

        // randomized operands, press lengths, scroll chatter, mid-run operand changes
        for (int op = 0; op < 40; op++) begin
            bus.X = 8'($urandom);
            bus.Y = 8'($urandom);
            k = $urandom_range(1, 6);
            for (int c = 0; c < 40; c++) begin
                bus.startMult = (c < k);
                bus.scrLeft   = ($urandom_range(0, 3) == 0);
                bus.scrRight  = ($urandom_range(0, 3) == 0);
                if (c == 12) bus.X = 8'($urandom);
                @(negedge clkin);
            end
        end
        bus.startMult = 0; bus.scrLeft = 0; bus.scrRight = 0;
        repeat (40) @(negedge clkin);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
Sequencing controller for the 8x8 multiply-and-display path. It synchronises and edge-detects the startMult/scrLeft/scrRight push-buttons, runs an iterative shift-add multiply, then a sequential double-dabble binary-to-BCD conversion. It also owns the 4-digit display window position over the BCD result. Its outputs feed the existing 7-segment scan/driver logic, which displays win_digits.

Parameters:
W, 8, operand width; product is 2W bits
ND, 5, BCD digit count of the result (must hold (2^W-1)^2; 5 for W=8)
DB_CYCLES, 16, debounce stability count (used only with the optional feature)

Ports:
clkin  in  1  system clock
rst  in  1  asynchronous reset, active-high
X  in  W  multiplicand, sampled at start
Y  in  W  multiplier, sampled at start
startMult  in  1  raw start button
scrLeft  in  1  raw scroll-left button (toward more significant digits)
scrRight  in  1  raw scroll-right button (toward less significant digits)
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse when product and bcd are valid
product  out  2W  binary product, held until the next accepted start
bcd  out  4*ND  BCD of product, digit 0 in bits [3:0]
win_pos  out  3  window offset, 0..ND-4
win_digits  out  16  bcd digits win_pos+3..win_pos, i.e. bcd >> (4*win_pos), low 16 bits
more_left  out  1  high if any digit above the window is nonzero

Behaviour:
- Reset (async, any state): FSM to IDLE; busy, done, product, bcd, win_pos, more_left, all sync and edge registers cleared to 0. Reset mid-operation discards the partial result.
- Button path: each button goes through 2-FF synchroniser, then a rising-edge detect (sync2 & ~prev) giving a 1-cycle pulse. A level held high produces exactly one pulse.
- FSM states: IDLE, MULT, BCD, DONE.
- IDLE: on start pulse, latch X->a, Y->b, clear accumulator, load counter=W, enter MULT, busy=1. Start pulses outside IDLE are ignored (no queuing).
- MULT: W cycles. Each cycle: if b[0], acc += a << i (2W-bit, no overflow possible); b >>= 1; i++. After W cycles: product<=acc, enter BCD.
- BCD: 2W cycles of double-dabble. Each cycle: every digit >=5 gets +3, then shift {digits, bin} left 1. After 2W cycles: bcd<=digits, enter DONE.
- DONE: done=1 for exactly this cycle, busy=0, win_pos<=0, return to IDLE next edge.
- Latency: FSM leaves IDLE on the 3rd rising edge after startMult is first sampled high. done is high 3W+1 cycles after leaving IDLE (25 for W=8).
- During MULT/BCD, product and bcd hold their previous values. They update only at the end of each phase.
- Scroll: left pulse increments win_pos, saturating at ND-4. Right pulse decrements, saturating at 0. Both in the same cycle: no change. Scroll is accepted in every state. A scroll in the same cycle as DONE is overridden by the reset to 0.
- win_digits and more_left are combinational from bcd and win_pos.

Optional Feature:
BTN_DEBOUNCE_EN.
- Defined: a debounce counter per button is inserted after the synchroniser. The debounced level changes only after the synchronised input differs from it for DB_CYCLES consecutive cycles; the edge detect acts on the debounced level. Start latency grows by DB_CYCLES.
- Undefined: no counter; edge detect acts directly on the synchronised level, with latency as stated above.

Test Plan:
- X=13, Y=5, startMult held 10 us -> single done pulse; product=0x0041, bcd=0x00065, win_digits=0x0065, more_left=0; exactly one multiply run despite the long press.
- X=255, Y=255, start -> product=0xFE01, bcd=0x65025, win_digits=0x5025, more_left=1. Then scrLeft -> win_pos=1, win_digits=0x6502, more_left=0. scrLeft again -> stays 1. scrRight -> win_pos=0.
- X=0, Y=200 -> product=0, bcd=0. Also X=1, Y=1 -> product=1. done occurs exactly 25 cycles after leaving IDLE (macro undefined).
- Second start pulse while busy (X changed to 7) -> ignored; result still reflects the first operands; busy stays high continuously until done.
- rst pulsed during MULT -> immediately busy=0, product=0, bcd=0, win_pos=0. A new start afterwards completes correctly.
- scrLeft and scrRight in the same cycle -> win_pos unchanged. With BTN_DEBOUNCE_EN, a 5-cycle glitch on startMult -> no start.
